// File: rtl/sys_arr_row_feeder.sv
// Row operand feeder: drains a show-ahead FIFO into the array west edge with SKEW lead / DRAIN trail zero cycles.
// Pop-to-pe_dat latency 1 cycle; an empty FIFO inserts a bubble and bumps underrun_cnt.
module sys_arr_row_feeder #(
    parameter int DW    = 32,
    parameter int K_MAX = 16,
    parameter int SKEW  = 0,
    parameter int DRAIN = 0,
    parameter int LW    = $clog2(K_MAX + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          fifo_is_empty,
    input  logic [DW-1:0] fifo_dat_out,
    output logic          fifo_pop,
    output logic [DW-1:0] pe_dat,
    output logic          pe_vld,
    output logic          busy,
    output logic          done,
    output logic [15:0]   underrun_cnt
);
    localparam int PAD_MAX = (SKEW > DRAIN) ? SKEW : DRAIN;
    localparam int CW      = (PAD_MAX > 1) ? $clog2(PAD_MAX) : 1;
    localparam logic [CW-1:0] SKEW_LAST  = CW'((SKEW > 0) ? SKEW - 1 : 0);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN > 0) ? DRAIN - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKEW,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [CW-1:0] pad_q, pad_d;
    logic [DW-1:0] pe_dat_q, pe_dat_d;
    logic          pe_vld_q, pe_vld_d;
    logic          done_q, done_d;
    logic [15:0]   urun_q, urun_d;
    logic          pop;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pad_d   = pad_q;
        urun_d  = urun_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    urun_d = '0;
                    pad_d  = '0;
                    rem_d  = len;
                    if (len == '0)
                        state_d = S_DONE;
                    else if (SKEW > 0)
                        state_d = S_SKEW;
                    else
                        state_d = S_STREAM;
                end
            end
            S_SKEW: begin
                if (pad_q == SKEW_LAST) begin
                    pad_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    pad_d = pad_q + CW'(1);
                end
            end
            S_STREAM: begin
                if (fifo_is_empty) begin
                    if (urun_q != 16'hFFFF)
                        urun_d = urun_q + 16'd1;
                end else begin
                    pop   = 1'b1;
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1))
                        state_d = (DRAIN > 0) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                if (pad_q == DRAIN_LAST) begin
                    pad_d   = '0;
                    state_d = S_DONE;
                end else begin
                    pad_d = pad_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        pe_vld_d = pop;
        pe_dat_d = pop ? fifo_dat_out : '0;
        done_d   = (state_q == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            pad_q    <= '0;
            pe_dat_q <= '0;
            pe_vld_q <= 1'b0;
            done_q   <= 1'b0;
            urun_q   <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            pad_q    <= pad_d;
            pe_dat_q <= pe_dat_d;
            pe_vld_q <= pe_vld_d;
            done_q   <= done_d;
            urun_q   <= urun_d;
        end
    end

    // A reset edge must not also consume a FIFO word.
    assign fifo_pop     = pop && !RST;
    assign pe_dat       = pe_dat_q;
    assign pe_vld       = pe_vld_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign underrun_cnt = urun_q;
endmodule

// File: tb/tb_sys_arr_row_feeder.sv
// Directed bench for sys_arr_row_feeder: one skewed/drained row instance (a) and one unskewed instance (b),
// each fed by a show-ahead FIFO model held in a queue.
module tb_sys_arr_row_feeder;
    localparam int DW = 32;
    localparam int LW = 5;

    logic          CLK;
    logic          RST;
    logic          start_a, start_b;
    logic [LW-1:0] len_a, len_b;
    logic          fifo_empty_a, fifo_empty_b;
    logic [DW-1:0] fifo_dat_a, fifo_dat_b;
    logic          fifo_pop_a, fifo_pop_b;
    logic [DW-1:0] pe_dat_a, pe_dat_b;
    logic          pe_vld_a, pe_vld_b;
    logic          busy_a, busy_b;
    logic          done_a, done_b;
    logic [15:0]   urun_a, urun_b;

    sys_arr_row_feeder #(.DW(DW), .K_MAX(16), .SKEW(2), .DRAIN(1)) u_dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .len(len_a),
        .fifo_is_empty(fifo_empty_a), .fifo_dat_out(fifo_dat_a), .fifo_pop(fifo_pop_a),
        .pe_dat(pe_dat_a), .pe_vld(pe_vld_a), .busy(busy_a), .done(done_a), .underrun_cnt(urun_a)
    );

    sys_arr_row_feeder #(.DW(DW), .K_MAX(16), .SKEW(0), .DRAIN(0)) u_dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .len(len_b),
        .fifo_is_empty(fifo_empty_b), .fifo_dat_out(fifo_dat_b), .fifo_pop(fifo_pop_b),
        .pe_dat(pe_dat_b), .pe_vld(pe_vld_b), .busy(busy_b), .done(done_b), .underrun_cnt(urun_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned qa[$];
    int unsigned qb[$];
    logic        pend_a, pend_b;
    int          pops_a, pops_b, bad_pops;
    int          n_checks, n_errors;
    int          exp_dat [0:23];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present FIFO heads, let combinational pop settle, and remember it for the coming edge.
    task automatic settle();
        fifo_empty_a = (qa.size() == 0);
        fifo_dat_a   = '0;
        if (qa.size() != 0) fifo_dat_a = qa[0];
        fifo_empty_b = (qb.size() == 0);
        fifo_dat_b   = '0;
        if (qb.size() != 0) fifo_dat_b = qb[0];
        #1;
        pend_a = fifo_pop_a;
        pend_b = fifo_pop_b;
        if (fifo_pop_a && qa.size() == 0) bad_pops++;
        if (fifo_pop_b && qb.size() == 0) bad_pops++;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        if (pend_a && qa.size() != 0) begin
            void'(qa.pop_front());
            pops_a++;
        end
        if (pend_b && qb.size() != 0) begin
            void'(qb.pop_front());
            pops_b++;
        end
        settle();
    endtask

    // Cycle k=1 is the edge that samples start; exp_dat[k] < 0 means a bubble is expected.
    task automatic run_trace(input bit on_a, input string name, input int n, input int done_at,
                             input bit restart, input int push_at, input int push_first, input int push_n);
        logic [31:0] vld, dat, dn;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 1) begin
                start_a = 1'b0;
                start_b = restart;
                len_b   = LW'(5);
                settle();
            end else if (k == 2 && restart) begin
                start_b = 1'b0;
                settle();
            end
            if (k == push_at) begin
                for (int i = 0; i < push_n; i++) qb.push_back(push_first + i);
                settle();
            end
            vld = on_a ? 32'(pe_vld_a) : 32'(pe_vld_b);
            dat = on_a ? pe_dat_a : pe_dat_b;
            dn  = on_a ? 32'(done_a) : 32'(done_b);
            check($sformatf("%s vld k=%0d", name, k), vld, 32'(exp_dat[k] >= 0));
            check($sformatf("%s dat k=%0d", name, k), dat, (exp_dat[k] >= 0) ? 32'(exp_dat[k]) : 32'd0);
            check($sformatf("%s done k=%0d", name, k), dn, 32'(k == done_at));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pops_a = 0;
        pops_b = 0;
        bad_pops = 0;
        RST = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        len_a = '0;
        len_b = '0;
        settle();
        tick();
        tick();
        check("rst vld_a", 32'(pe_vld_a), 0);
        check("rst dat_a", pe_dat_a, 0);
        check("rst busy_a", 32'(busy_a), 0);
        check("rst done_b", 32'(done_b), 0);
        check("rst urun_b", 32'(urun_b), 0);
        check("rst busy_b", 32'(busy_b), 0);
        RST = 1'b0;
        settle();
        tick();

        // 1: SKEW=2, DRAIN=1, four words ready.
        for (int i = 1; i <= 4; i++) qa.push_back(i);
        pops_a = 0;
        start_a = 1'b1;
        len_a = LW'(4);
        settle();
        exp_dat = '{4:1, 5:2, 6:3, 7:4, default:-1};
        run_trace(1'b1, "t1", 9, 9, 1'b0, 0, 0, 0);
        check("t1 fifo left", qa.size(), 0);
        check("t1 pops", pops_a, 4);
        check("t1 urun", 32'(urun_a), 0);
        check("t1 busy", 32'(busy_a), 0);

        // 2: underrun gap of three cycles in a len=6 job.
        qb.push_back(1);
        qb.push_back(2);
        pops_b = 0;
        start_b = 1'b1;
        len_b = LW'(6);
        settle();
        exp_dat = '{2:1, 3:2, 7:3, 8:4, 9:5, 10:6, default:-1};
        run_trace(1'b0, "t2", 11, 11, 1'b0, 6, 3, 4);
        check("t2 urun", 32'(urun_b), 3);
        check("t2 pops", pops_b, 6);

        // 3: zero-length job must not pop the waiting word.
        qb.push_back(9);
        pops_b = 0;
        start_b = 1'b1;
        len_b = '0;
        settle();
        exp_dat = '{default:-1};
        run_trace(1'b0, "t3", 3, 2, 1'b0, 0, 0, 0);
        check("t3 pops", pops_b, 0);
        check("t3 fifo left", qb.size(), 1);

        // 4: a second start while busy is ignored.
        for (int i = 20; i <= 24; i++) qb.push_back(i);
        pops_b = 0;
        start_b = 1'b1;
        len_b = LW'(3);
        settle();
        exp_dat = '{2:9, 3:20, 4:21, default:-1};
        run_trace(1'b0, "t4", 8, 5, 1'b1, 0, 0, 0);
        check("t4 pops", pops_b, 3);
        check("t4 fifo left", qb.size(), 3);
        check("t4 urun", 32'(urun_b), 0);
        check("t4 busy", 32'(busy_b), 0);

        // 5: reset after two words of a len=8 job, then a fresh job.
        for (int i = 30; i <= 34; i++) qb.push_back(i);
        pops_b = 0;
        start_b = 1'b1;
        len_b = LW'(8);
        settle();
        tick();
        start_b = 1'b0;
        settle();
        tick();
        check("t5 w1 dat", pe_dat_b, 22);
        tick();
        check("t5 w2 dat", pe_dat_b, 23);
        RST = 1'b1;
        settle();
        tick();
        check("t5 rst vld", 32'(pe_vld_b), 0);
        check("t5 rst busy", 32'(busy_b), 0);
        check("t5 rst done", 32'(done_b), 0);
        RST = 1'b0;
        settle();
        tick();
        check("t5 post done", 32'(done_b), 0);
        check("t5 pops", pops_b, 2);
        check("t5 fifo left", qb.size(), 6);
        pops_b = 0;
        start_b = 1'b1;
        len_b = LW'(2);
        settle();
        exp_dat = '{2:24, 3:30, default:-1};
        run_trace(1'b0, "t5b", 4, 4, 1'b0, 0, 0, 0);
        check("t5b pops", pops_b, 2);

        // 6: full FIFO, len=K_MAX streams back to back.
        qb.delete();
        for (int i = 1; i <= 16; i++) qb.push_back(i);
        pops_b = 0;
        start_b = 1'b1;
        len_b = LW'(16);
        settle();
        exp_dat = '{default:-1};
        for (int k = 2; k <= 17; k++) exp_dat[k] = k - 1;
        run_trace(1'b0, "t6", 19, 18, 1'b0, 0, 0, 0);
        check("t6 fifo left", qb.size(), 0);
        check("t6 pops", pops_b, 16);
        check("t6 urun", 32'(urun_b), 0);

        check("pop while empty", bad_pops, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
